// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: default widths,
// FSM state encoding and requester port ids.
package mem_arbiter_pkg;

  localparam int unsigned AW_DEF = 13;
  localparam int unsigned DW_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-input round-robin picker: a lone request wins, a tie goes to the
// port that was not granted last.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  always_comb begin
    grant = PORT0;
    if (req0 && req1) begin
      grant = (last == PORT0) ? PORT1 : PORT0;
    end else if (req1) begin
      grant = PORT1;
    end
  end

  assign valid = req0 | req1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter for a single shared memory: IDLE picks a
// winner, ACCESS drives the memory for one cycle, RESP acks the winner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          we0,
  input  logic          we1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_read_data
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last;
  logic          r_port;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_ack0;
  logic          r_ack1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_grant;
  logic          w_valid;
  logic          w_latch;
  logic          w_capture;
  logic          w_ack0_nxt;
  logic          w_ack1_nxt;
  logic          w_in_access;
  logic [AW-1:0] w_sel_addr;
  logic          w_sel_we;
  logic [DW-1:0] w_sel_wdata;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (r_last),
    .grant (w_grant),
    .valid (w_valid)
  );

  assign w_sel_addr  = (w_grant == PORT1) ? addr1  : addr0;
  assign w_sel_we    = (w_grant == PORT1) ? we1    : we0;
  assign w_sel_wdata = (w_grant == PORT1) ? wdata1 : wdata0;

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_state_nxt = ST_ACCESS;
          w_latch     = 1'b1;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_RESP;
        w_capture   = ~r_we;
        w_ack0_nxt  = (r_port == PORT0);
        w_ack1_nxt  = (r_port == PORT1);
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched request operands; only loaded on the IDLE->ACCESS transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= PORT1;
      r_port  <= PORT0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_last  <= w_grant;
      r_port  <= w_grant;
      r_we    <= w_sel_we;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_ack0 <= w_ack0_nxt;
      r_ack1 <= w_ack1_nxt;
      if (w_capture && (r_port == PORT0)) r_rdata0 <= mem_read_data;
      if (w_capture && (r_port == PORT1)) r_rdata1 <= mem_read_data;
    end
  end

  // Memory side is gated by the state register so reset kills a write at once.
  assign w_in_access    = (r_state == ST_ACCESS);
  assign mem_read       = w_in_access & ~r_we;
  assign mem_write      = w_in_access & r_we;
  assign mem_address    = w_in_access ? r_addr  : '0;
  assign mem_write_data = w_in_access ? r_wdata : '0;

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, timestamp-based transaction model,
// per-cycle output comparison, directed scenarios and random two-port traffic.
module tb_mem_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;
  localparam int unsigned NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_read_data;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem     [NW];
  logic [DW-1:0] ref_mem [NW];

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0           (req0),
    .req1           (req1),
    .addr0          (addr0),
    .addr1          (addr1),
    .we0            (we0),
    .we1            (we1),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .ack0           (ack0),
    .ack1           (ack1),
    .rdata0         (rdata0),
    .rdata1         (rdata1),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Shared memory: combinational read, write on the clock edge.
  assign mem_read_data = mem_read ? mem[mem_address] : '0;
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request seen in a free cycle starts a transaction whose
  // memory cycle is the next cycle (m_start) and whose ack is the one after.
  int            cyc     = 0;
  int            m_start = 0;
  bit            m_busy  = 0;
  bit            m_prev_idle;
  bit            m_last  = 1;
  bit            m_port  = 0;
  bit            m_we    = 0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] exp_rd0 = '0;
  logic [DW-1:0] exp_rd1 = '0;

  always @(posedge clk) begin
    m_prev_idle = !m_busy;
    cyc = cyc + 1;
    if (rst) begin
      m_busy  = 0;
      m_last  = 1;
      m_port  = 0;
      m_we    = 0;
      m_addr  = '0;
      m_wdata = '0;
      exp_rd0 = '0;
      exp_rd1 = '0;
    end else if (m_prev_idle) begin
      if (req0 || req1) begin
        if (req0 && req1) m_port = (m_last == 1) ? 1'b0 : 1'b1;
        else              m_port = req1;
        m_last  = m_port;
        m_we    = (m_port == 0) ? we0 : we1;
        m_addr  = (m_port == 0) ? addr0 : addr1;
        m_wdata = (m_port == 0) ? wdata0 : wdata1;
        m_busy  = 1;
        m_start = cyc;
      end
    end else if (cyc == m_start + 1) begin
      if (m_we)             ref_mem[m_addr] = m_wdata;
      else if (m_port == 0) exp_rd0 = ref_mem[m_addr];
      else                  exp_rd1 = ref_mem[m_addr];
    end else if (cyc == m_start + 2) begin
      m_busy = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit in_acc, in_resp;
    in_acc  = m_busy && (cyc == m_start);
    in_resp = m_busy && (cyc == m_start + 1);
    check("mem_read",       32'(mem_read),       32'(in_acc && !m_we));
    check("mem_write",      32'(mem_write),      32'(in_acc && m_we));
    check("mem_address",    32'(mem_address),    in_acc ? 32'(m_addr) : 32'd0);
    check("mem_write_data", 32'(mem_write_data), in_acc ? 32'(m_wdata) : 32'd0);
    check("ack0",           32'(ack0),           32'(in_resp && m_port == 0));
    check("ack1",           32'(ack1),           32'(in_resp && m_port == 1));
    check("rdata0",         32'(rdata0),         32'(exp_rd0));
    check("rdata1",         32'(rdata1),         32'(exp_rd1));
    check("ack_both",       32'(ack0 && ack1),   32'd0);
  end

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 100) return 16'd10;
    if (i == 120) return 16'd0;
    return 16'(i * 37 + 5);
  endfunction

  task automatic set_req(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? ack0 : ack1;
  endfunction

  // Called at posedge+1; returns read data and cycles-to-ack counted from the request cycle.
  task automatic run_txn(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output logic [DW-1:0] rd, output int lat);
    bit got;
    got = 0;
    lat = 0;
    rd  = '0;
    set_req(p, 1'b1, w, a, d);
    for (int t = 0; t < 12 && !got; t++) begin
      @(negedge clk);
      lat++;
      if (ack_of(p)) begin
        got = 1;
        rd  = (p == 0) ? rdata0 : rdata1;
      end
    end
    check("txn_ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    set_req(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic drive_port(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int gap;
      bit got;
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        set_req(p, 1'b0, 1'b0, '0, '0);
        repeat (gap) @(posedge clk);
        #1;
      end
      set_req(p, 1'b1, 1'($urandom), AW'(200 + $urandom_range(0, 15)), DW'($urandom));
      got = 0;
      for (int t = 0; t < 12 && !got; t++) begin
        @(negedge clk);
        if (ack_of(p)) got = 1;
      end
      check("rand_ack_seen", 32'(got), 32'd1);
      @(posedge clk); #1;
    end
    set_req(p, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    int            lat;
    int            got_port[$];
    int            got_cyc[$];
    int            nack;

    for (int i = 0; i < int'(NW); i++) begin
      mem[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack0",     32'(ack0), 32'd0);
    check("rst_rdata1",   32'(rdata1), 32'd0);
    check("rst_mem_addr", 32'(mem_address), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Read of word 100 (holds 10): strobe next cycle, ack the cycle after.
    set_req(0, 1'b1, 1'b0, AW'(100), '0);
    @(negedge clk);
    @(negedge clk);
    check("rd100_mem_read", 32'(mem_read), 32'd1);
    check("rd100_mem_addr", 32'(mem_address), 32'd100);
    @(negedge clk);
    check("rd100_ack0",   32'(ack0), 32'd1);
    check("rd100_rdata0", 32'(rdata0), 32'd10);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);

    // Write then read back word 150 on port 1.
    run_txn(1, 1'b1, AW'(150), 16'h00AB, rd, lat);
    check("wr150_latency", 32'(lat), 32'd3);
    run_txn(1, 1'b0, AW'(150), '0, rd, lat);
    check("rd150_rdata1", 32'(rd), 32'h00AB);
    check("rd150_latency", 32'(lat), 32'd3);
    check("rd150_rdata0_kept", 32'(rdata0), 32'd10);

    // Both ports held high from reset release: alternate 0,1,0,1 every 3 cycles.
    @(negedge clk); #1;
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, AW'(100), '0);
    set_req(1, 1'b1, 1'b0, AW'(150), '0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 30 && got_port.size() < 4; t++) begin
      @(negedge clk);
      if (ack0) begin got_port.push_back(0); got_cyc.push_back(cyc); end
      if (ack1) begin got_port.push_back(1); got_cyc.push_back(cyc); end
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    check("rr_ack_count", 32'(got_port.size()), 32'd4);
    if (got_port.size() == 4) begin
      for (int i = 0; i < 4; i++) check("rr_order", 32'(got_port[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) check("rr_spacing", 32'(got_cyc[i] - got_cyc[i-1]), 32'd3);
    end

    // Reset during the memory cycle of a port-1 write to word 120.
    set_req(1, 1'b1, 1'b1, AW'(120), 16'h1234);
    @(posedge clk);
    @(negedge clk);
    check("abort_mem_write_before", 32'(mem_write), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_mem_write_async", 32'(mem_write), 32'd0);
    check("abort_mem_addr_async",  32'(mem_address), 32'd0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    nack = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack0 || ack1) nack++;
    end
    check("abort_no_ack", 32'(nack), 32'd0);
    check("abort_rdata0_reset", 32'(rdata0), 32'd0);
    check("abort_rdata1_reset", 32'(rdata1), 32'd0);
    @(posedge clk); #1;
    run_txn(0, 1'b0, AW'(120), '0, rd, lat);
    check("abort_word120", 32'(rd), 32'd0);

    // Port 0 alone held high: an ack every 3 cycles.
    got_cyc.delete();
    set_req(0, 1'b1, 1'b0, AW'(100), '0);
    for (int t = 0; t < 20 && got_cyc.size() < 3; t++) begin
      @(negedge clk);
      if (ack0) begin
        got_cyc.push_back(cyc);
        check("solo_mem_read_in_resp", 32'(mem_read), 32'd0);
      end
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    check("solo_ack_count", 32'(got_cyc.size()), 32'd3);
    if (got_cyc.size() == 3) begin
      for (int i = 1; i < 3; i++) check("solo_spacing", 32'(got_cyc[i] - got_cyc[i-1]), 32'd3);
    end

    // Random two-port traffic.
    fork
      drive_port(0, 60);
      drive_port(1, 60);
    join
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
